// File: rtl/if_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_pkg
//   Shared definitions for the fetch-stage controller of the 16-bit core:
//   FSM state encoding, IF PC-mux select codes, the HALT opcode and a
//   saturating increment used by the optional performance counters.
// ---------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // IF PC mux select; code 3 is never produced.
  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [15:0] PERF_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == PERF_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard detector. Flags when the instruction in EX
//   is a load whose destination feeds either source of the instruction in ID.
//   Register r0 is hard-wired zero, so a load to r0 never creates a hazard.
//
// Ports:
//   i_ex_is_load  EX instruction is a load
//   i_ex_dest     EX destination register
//   i_src1_id     ID source register 1
//   i_src2_id     ID source register 2
//   o_hit         load-use hazard present
// ---------------------------------------------------------------------------
module load_use_detect (
  input  logic       i_ex_is_load,
  input  logic [3:0] i_ex_dest,
  input  logic [3:0] i_src1_id,
  input  logic [3:0] i_src2_id,
  output logic       o_hit
);

  logic w_dest_nonzero;
  logic w_src_match;

  assign w_dest_nonzero = (i_ex_dest != 4'd0);
  assign w_src_match    = (i_ex_dest == i_src1_id) || (i_ex_dest == i_src2_id);
  assign o_hit          = i_ex_is_load && w_dest_nonzero && w_src_match;

endmodule

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//   Fetch-stage controller. Drives the IF PC-source select, the Hazard
//   (rewind PC / hold IF-ID) and Halt inputs; sequences branch/jump
//   redirects with a two-slot IF/ID flush, inserts one bubble per load-use
//   hazard and drains the pipeline on a HALT opcode.
//
// Optional feature macro: IF_FETCH_CTRL_PERF_EN adds saturating stall/flush
//   counters and their output ports.
//
// Parameters:
//   DRAIN_CYCLES  cycles for EX/MEM/WB to retire after HALT is seen (>= 1)
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous reset, active low
//   opcode_ID        opcode in ID
//   src1_ID/src2_ID  source registers in ID
//   ex_is_load       EX instruction is a load
//   ex_dest          EX destination register
//   ex_branch_taken  conditional branch in EX resolved taken
//   ex_jump          jump in EX
//   PCSource         IF PC mux select (combinational)
//   Hazard           rewind PC by 2 and hold IF/ID (combinational)
//   flush            zero IF/ID at next edge (combinational)
//   Halt             freeze PC (registered)
//   halted           pipeline drained, core stopped (registered)
//   stall_count      cycles with Hazard=1 (perf build only)
//   flush_count      cycles with flush=1 (perf build only)
// ---------------------------------------------------------------------------
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode_ID,
  input  logic [3:0]  src1_ID,
  input  logic [3:0]  src2_ID,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_dest,
  input  logic        ex_branch_taken,
  input  logic        ex_jump,
  output logic [1:0]  PCSource,
  output logic        Hazard,
  output logic        flush,
  output logic        Halt,
  output logic        halted
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  // DRAIN holds for DRAIN_CYCLES cycles: the counter is loaded with N-1 and
  // the exit to HALTED happens on the cycle it reads zero.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_halt;
  logic             r_halted;
  logic             w_lu_hit;

  load_use_detect u_load_use_detect (
    .i_ex_is_load (ex_is_load),
    .i_ex_dest    (ex_dest),
    .i_src1_id    (src1_ID),
    .i_src2_id    (src2_ID),
    .o_hit        (w_lu_hit)
  );

  // NOTE: every signal written here gets a default before the case so that
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next_state = r_state;
    PCSource     = PCSRC_SEQ;
    Hazard       = 1'b0;
    flush        = 1'b0;

    unique case (r_state)
      // STALL shares RUN's redirect handling but masks load-use and HALT:
      // the held ID instruction is re-evaluated once back in RUN.
      ST_RUN, ST_STALL: begin
        if (ex_jump) begin
          PCSource     = PCSRC_JMP;
          flush        = 1'b1;
          w_next_state = ST_FLUSH;
        end else if (ex_branch_taken) begin
          PCSource     = PCSRC_BR;
          flush        = 1'b1;
          w_next_state = ST_FLUSH;
        end else if (r_state == ST_RUN && w_lu_hit) begin
          Hazard       = 1'b1;
          w_next_state = ST_STALL;
        end else if (r_state == ST_RUN && opcode_ID == OP_HALT) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      // Second flush slot squashes the other wrong-path instruction.
      ST_FLUSH: begin
        flush        = 1'b1;
        w_next_state = ST_RUN;
      end
      // Older instructions are already resolved, so EX/ID inputs are ignored.
      ST_DRAIN: begin
        w_next_state = (r_drain_cnt == '0) ? ST_HALTED : ST_DRAIN;
      end
      ST_HALTED: begin
        w_next_state = ST_HALTED;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    // Keep IF quiet while reset is held, whatever the EX/ID inputs show.
    if (!reset) begin
      PCSource = PCSRC_SEQ;
      Hazard   = 1'b0;
      flush    = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halt      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halt   <= (w_next_state == ST_DRAIN) || (w_next_state == ST_HALTED);
      r_halted <= (w_next_state == ST_HALTED);
      if (r_state != ST_DRAIN && w_next_state == ST_DRAIN) begin
        r_drain_cnt <= CNT_INIT;
      end else if (r_state == ST_DRAIN && r_drain_cnt != '0) begin
        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
      end
    end
  end

  assign Halt   = r_halt;
  assign halted = r_halted;

`ifdef IF_FETCH_CTRL_PERF_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (r_state != ST_HALTED) begin
      if (Hazard) r_stall_count <= sat_inc(r_stall_count);
      if (flush)  r_flush_count <= sat_inc(r_flush_count);
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       ld;
    logic [3:0] dst;
    logic       br;
    logic       jp;
  } stim_t;

  typedef struct packed {
    logic [1:0] pc;
    logic       hz;
    logic       fl;
    logic       halt;
    logic       halted;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode_ID;
  logic [3:0]  src1_ID;
  logic [3:0]  src2_ID;
  logic        ex_is_load;
  logic [3:0]  ex_dest;
  logic        ex_branch_taken;
  logic        ex_jump;
  logic [1:0]  PCSource;
  logic        Hazard;
  logic        flush;
  logic        Halt;
  logic        halted;
`ifdef IF_FETCH_CTRL_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  int errors = 0;
  int checks = 0;
  out_t sb_q[$];

  if_fetch_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_ID       (opcode_ID),
    .src1_ID         (src1_ID),
    .src2_ID         (src2_ID),
    .ex_is_load      (ex_is_load),
    .ex_dest         (ex_dest),
    .ex_branch_taken (ex_branch_taken),
    .ex_jump         (ex_jump),
    .PCSource        (PCSource),
    .Hazard          (Hazard),
    .flush           (flush),
    .Halt            (Halt),
    .halted          (halted)
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic stim_t mk_s(input logic [3:0] op, input logic [3:0] s1, input logic [3:0] s2,
                                 input logic ld, input logic [3:0] dst, input logic br, input logic jp);
    stim_t s;
    s.op = op; s.s1 = s1; s.s2 = s2; s.ld = ld; s.dst = dst; s.br = br; s.jp = jp;
    return s;
  endfunction

  function automatic out_t mk_o(input logic [1:0] pc, input logic hz, input logic fl,
                                input logic halt, input logic hd);
    out_t o;
    o.pc = pc; o.hz = hz; o.fl = fl; o.halt = halt; o.halted = hd;
    return o;
  endfunction

  function automatic stim_t idle();
    return mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
  endfunction

  function automatic out_t observe();
    return mk_o(PCSource, Hazard, flush, Halt, halted);
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("pc=%0d hz=%b fl=%b halt=%b halted=%b", o.pc, o.hz, o.fl, o.halt, o.halted);
  endfunction

  task automatic drive(input stim_t s);
    opcode_ID       = s.op;
    src1_ID         = s.s1;
    src2_ID         = s.s2;
    ex_is_load      = s.ld;
    ex_dest         = s.dst;
    ex_branch_taken = s.br;
    ex_jump         = s.jp;
  endtask

  // Drive one cycle's inputs on the falling edge, queue what the DUT must
  // show this cycle, and leave time for the combinational outputs to settle.
  task automatic apply(input stim_t s, input out_t e);
    @(negedge clk);
    drive(s);
    sb_q.push_back(e);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(idle());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    out_t obs, exp;
    reset = 1'b0;
    drive(mk_s(4'hF, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1));
    for (int i = 0; i < 2; i++) begin
      #2;
      sb_q.push_back(mk_o(2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(obs), fmt(exp));
      end
      @(posedge clk);
    end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d, expected 0 and 0", stall_count, flush_count);
    end
`endif
    @(negedge clk);
    drive(idle());
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t st[$];
    out_t  ex[$];
    out_t  obs, exp;
    do_reset();
    st.push_back(mk_s(4'h0, 4'd3, 4'd7, 1'b1, 4'd3, 1'b0, 1'b0)); ex.push_back(mk_o(0, 1, 0, 0, 0));
    st.push_back(mk_s(4'h0, 4'd3, 4'd7, 1'b1, 4'd3, 1'b0, 1'b0)); ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(mk_s(4'h0, 4'd9, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0)); ex.push_back(mk_o(0, 1, 0, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL load_use[%0d]: got %s, expected %s", i, fmt(obs), fmt(exp));
      end
    end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++;
    if (stall_count !== 16'd2 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL load_use_counters: got stall=%0d flush=%0d, expected 2 and 0", stall_count, flush_count);
    end
`endif
  endtask

  task automatic test_no_hazard();
    stim_t st[$];
    out_t  ex[$];
    out_t  obs, exp;
    do_reset();
    st.push_back(mk_s(4'h0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0)); ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(mk_s(4'h0, 4'd0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0)); ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(mk_s(4'h0, 4'd1, 4'd2, 1'b1, 4'd3, 1'b0, 1'b0)); ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(mk_s(4'h0, 4'd3, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0)); ex.push_back(mk_o(0, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL no_hazard[%0d]: got %s, expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    out_t  ex[$];
    out_t  obs, exp;
    do_reset();
    st.push_back(mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back(mk_o(1, 0, 1, 0, 0));
    st.push_back(mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back(mk_o(0, 0, 1, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL branch[%0d]: got %s, expected %s", i, fmt(obs), fmt(exp));
      end
    end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++;
    if (flush_count !== 16'd2 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL branch_counters: got stall=%0d flush=%0d, expected 0 and 2", stall_count, flush_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    out_t  ex[$];
    out_t  obs, exp;
    do_reset();
    st.push_back(mk_s(4'h0, 4'd6, 4'd2, 1'b1, 4'd6, 1'b0, 1'b0)); ex.push_back(mk_o(0, 1, 0, 0, 0));
    st.push_back(mk_s(4'h0, 4'd6, 4'd2, 1'b1, 4'd6, 1'b0, 1'b1)); ex.push_back(mk_o(2, 0, 1, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 1, 0, 0));
    st.push_back(mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back(mk_o(1, 0, 1, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 1, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %s, expected %s", i, fmt(obs), fmt(exp));
      end
    end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++;
    if (stall_count !== 16'd1 || flush_count !== 16'd4) begin
      errors++;
      $display("FAIL back_to_back_counters: got stall=%0d flush=%0d, expected 1 and 4", stall_count, flush_count);
    end
`endif
  endtask

  task automatic test_priority();
    stim_t st[$];
    out_t  ex[$];
    out_t  obs, exp;
    do_reset();
    st.push_back(mk_s(4'hF, 4'd3, 4'd7, 1'b1, 4'd3, 1'b1, 1'b1)); ex.push_back(mk_o(2, 0, 1, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 1, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(mk_s(4'hF, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back(mk_o(1, 0, 1, 0, 0));
    st.push_back(mk_s(4'hF, 4'd4, 4'd4, 1'b1, 4'd4, 1'b0, 1'b0)); ex.push_back(mk_o(0, 0, 1, 0, 0));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL priority[%0d]: got %s, expected %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_halt();
    stim_t st[$];
    out_t  ex[$];
    out_t  obs, exp;
    stim_t noisy;
    noisy = mk_s(4'hF, 4'd3, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1);
    do_reset();
    st.push_back(mk_s(4'hF, 4'd1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0)); ex.push_back(mk_o(0, 0, 0, 0, 0));
    st.push_back(noisy);                                         ex.push_back(mk_o(0, 0, 0, 1, 0));
    st.push_back(noisy);                                         ex.push_back(mk_o(0, 0, 0, 1, 0));
    st.push_back(noisy);                                         ex.push_back(mk_o(0, 0, 0, 1, 0));
    st.push_back(noisy);                                         ex.push_back(mk_o(0, 0, 0, 1, 1));
    st.push_back(mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0)); ex.push_back(mk_o(0, 0, 0, 1, 1));
    st.push_back(idle());                                        ex.push_back(mk_o(0, 0, 0, 1, 1));
    foreach (st[i]) begin
      apply(st[i], ex[i]);
      obs = observe();
      exp = sb_q.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt[%0d]: got %s, expected %s", i, fmt(obs), fmt(exp));
      end
    end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL halt_counters: got stall=%0d flush=%0d, expected 0 and 0", stall_count, flush_count);
    end
`endif
  endtask

  task automatic test_reset_abort();
    out_t obs, exp;
    do_reset();
    // Build up some counts, then enter DRAIN.
    apply(mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0), mk_o(1, 0, 1, 0, 0));
    void'(sb_q.pop_front());
    apply(idle(), mk_o(0, 0, 1, 0, 0));
    void'(sb_q.pop_front());
    apply(mk_s(4'hF, 4'd1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0), mk_o(0, 0, 0, 0, 0));
    void'(sb_q.pop_front());
    apply(idle(), mk_o(0, 0, 0, 1, 0));
    obs = observe();
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_in_drain: got %s, expected %s", fmt(obs), fmt(exp));
    end

    // Asynchronous reset in the middle of DRAIN, with a jump showing in EX.
    drive(mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b1));
    reset = 1'b0;
    #1;
    sb_q.push_back(mk_o(0, 0, 0, 0, 0));
    obs = observe();
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_reset_drain: got %s, expected %s", fmt(obs), fmt(exp));
    end
`ifdef IF_FETCH_CTRL_PERF_EN
    checks++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL abort_counters: got stall=%0d flush=%0d, expected 0 and 0", stall_count, flush_count);
    end
`endif
    @(negedge clk);
    drive(idle());
    reset = 1'b1;

    // Back in RUN: idle is quiet and a branch is honoured.
    apply(idle(), mk_o(0, 0, 0, 0, 0));
    obs = observe();
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_after_drain: got %s, expected %s", fmt(obs), fmt(exp));
    end
    apply(mk_s(4'h0, 4'd1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0), mk_o(1, 0, 1, 0, 0));
    obs = observe();
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_branch: got %s, expected %s", fmt(obs), fmt(exp));
    end

    // Now in FLUSH: reset must drop the second flush slot.
    reset = 1'b0;
    #1;
    @(negedge clk);
    drive(idle());
    reset = 1'b1;
    apply(idle(), mk_o(0, 0, 0, 0, 0));
    obs = observe();
    exp = sb_q.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_flush: got %s, expected %s", fmt(obs), fmt(exp));
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_back_to_back();
    test_priority();
    test_halt();
    test_reset_abort();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-stage controller for the 16-bit pipelined core. It drives the IF stage's PC-source select, Hazard (PC rewind / IF-ID hold) and Halt inputs. It detects load-use hazards against the instruction in ID and sequences branch/jump redirects with a two-slot IF/ID flush. It also drains the pipeline on a HALT opcode. It sits between the IF stage, the ID-stage decode fields and the EX-stage branch/load status.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles to let EX/MEM/WB retire after HALT is seen in ID.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- opcode_ID  in  4  opcode field currently in ID
- src1_ID, src2_ID  in  4 each  source register fields in ID
- ex_is_load  in  1  instruction in EX is a load
- ex_dest  in  4  destination register of EX instruction
- ex_branch_taken  in  1  conditional branch in EX resolved taken
- ex_jump  in  1  jump in EX
- PCSource  out  2  IF PC mux select: 0 sequential, 1 branch target (PCMux_1), 2 jump target (PCMux_2); 3 never driven
- Hazard  out  1  IF rewind PC by 2 and hold IF/ID
- flush  out  1  zero IF/ID contents at next edge
- Halt  out  1  freeze PC (registered)
- halted  out  1  pipeline drained, core stopped
- stall_count, flush_count  out  16 each  (only with IF_FETCH_CTRL_PERF_EN)

## Operation
- States: RUN, STALL, FLUSH, DRAIN, HALTED.
- RUN: evaluate events in this priority order, highest first:
  - ex_jump: PCSource=2, flush=1, next state FLUSH.
  - ex_branch_taken: PCSource=1, flush=1, next state FLUSH.
  - load-use: Hazard=1, next state STALL.
    - Condition: ex_is_load && ex_dest!=0 && (ex_dest==src1_ID || ex_dest==src2_ID).
  - opcode_ID==OP_HALT: next state DRAIN, Halt<=1, counter<=DRAIN_CYCLES-1.
  - Otherwise: PCSource=0, Hazard=0, flush=0, stay in RUN.
- STALL: one cycle. Load-use detection is masked. Branch/jump are still honoured as in RUN. Otherwise return to RUN.
- FLUSH: flush=1 for a second slot, PCSource=0, Hazard=0. Everything else is ignored. Next state RUN.
- DRAIN: Halt=1, all ID inputs ignored. Counter decrements each cycle; at 0, next state HALTED.
  - A branch/jump in EX during DRAIN cannot occur: the older instructions are already resolved. EX inputs are ignored.
- HALTED: Halt=1, halted=1. The state is sticky until reset.
- A branch/jump in the same cycle as a HALT in ID: the branch wins and the HALT is flushed as wrong-path.
- A branch/jump in the same cycle as load-use: the branch wins, and Hazard stays 0.

## Timing
- PCSource, Hazard and flush are combinational from state and inputs; they are valid in the same cycle as the triggering inputs.
- Halt and halted are registered. Halt rises on the edge after HALT is seen in ID. halted rises DRAIN_CYCLES edges later.
- Redirect latency: the target is fetched on the edge after ex_jump/ex_branch_taken. flush is asserted for exactly 2 consecutive cycles.
- Load-use costs exactly one bubble: Hazard is high for 1 cycle per load.
- Reset (async, low): state=RUN, Halt=0, halted=0, counter=0, perf counters=0. While reset is low, PCSource=0, Hazard=0 and flush=0. Reset asserted mid-DRAIN or mid-FLUSH aborts immediately to RUN after release.

## Configuration
- IF_FETCH_CTRL_PERF_EN defined:
  - stall_count increments on each cycle Hazard=1.
  - flush_count increments on each cycle flush=1.
  - Both are 16-bit, saturate at 16'hFFFF, are cleared by reset and are frozen in HALTED.
- Undefined: the counters and ports are absent and the rest of the behaviour is identical.

## Structure
- Package if_fetch_ctrl_pkg holds:
  - state encodings;
  - PCSRC_SEQ=2'd0, PCSRC_BR=2'd1, PCSRC_JMP=2'd2;
  - OP_HALT=4'hF.
- Sub-module load_use_detect is combinational: it takes ex_is_load, ex_dest, src1_ID and src2_ID and outputs hit.
- The FSM, drain counter and perf counters live in the top module.

## Test plan
- Load r3 in EX, src1_ID=3 -> Hazard=1 for one cycle, PCSource=0, STALL then RUN; stall_count=1.
- Load r0 in EX, src1_ID=0 -> Hazard stays 0.
- ex_branch_taken=1 -> PCSource=1 that cycle; flush=1 for 2 cycles; flush_count=2; then RUN.
- ex_jump=1 with ex_branch_taken=1 and a load-use hit -> PCSource=2, Hazard=0, flush for 2 cycles.
- opcode_ID=4'hF -> Halt=1 next edge; halted=1 after 3 more edges; further branches are ignored.
- Reset low during DRAIN -> Halt=0 and state=RUN immediately; counters are 0 after release.
